// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/capture stage wrapped around an external
// combinational alu. A command is registered, presented to the alu for
// SETTLE cycles, and the alu result is captured into an accumulator with
// zero/carry flags. The result is then offered downstream over valid/ready.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_carry,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic             accept;
   logic             capture;
   logic [WIDTH:0]   sum;
   logic             carry_nxt;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign capture   = (state == EXEC) && (cnt == '0);

   assign alu_a   = a_reg;
   assign alu_b   = b_reg;
   assign alu_sel = op_reg;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept -> settle -> respond -> idle, no overlap
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)      state_nxt = EXEC;
         EXEC:    if (cnt == '0)   state_nxt = RESP;
         RESP:    if (res_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Carry/borrow derived from the registered operands, not from alu_out,
   // since the alu only returns WIDTH bits
   always_comb begin
      sum       = {1'b0, a_reg} + {1'b0, b_reg};
      carry_nxt = 1'b0;
      case (op_reg)
         3'b000:  carry_nxt = sum[WIDTH];
         3'b001:  carry_nxt = (a_reg < b_reg);
         default: carry_nxt = 1'b0;
      endcase
   end

   // Operand/opcode registers feeding the alu; held outside of an accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= '0;
      end else if (accept) begin
         a_reg  <= cmd_use_acc ? acc : cmd_a;
         b_reg  <= cmd_b;
         op_reg <= cmd_op;
      end
   end

   // Settle counter: loaded on accept, counts down while in EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= CNT_INIT;
      end else if ((state == EXEC) && (cnt != '0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Result capture into the accumulator and flags at the end of settling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= '0;
         acc       <= '0;
         res_zero  <= 1'b0;
         res_carry <= 1'b0;
      end else if (capture) begin
         res_data  <= alu_out;
         acc       <= alu_out;
         res_zero  <= (alu_out == '0);
         res_carry <= carry_nxt;
      end
   end

   // Downstream valid: raised on capture, dropped on the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
      end else if (capture) begin
         res_valid <= 1'b1;
      end else if ((state == RESP) && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=3), each
// driving a small behavioural alu. Directed and random commands are checked
// against a transaction-level reference model.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sel;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       cmd_use_acc;
   logic       res_ready;

   logic       cmd_ready_s1, res_valid_s1, res_zero_s1, res_carry_s1;
   logic [7:0] alu_a_s1, alu_b_s1, alu_out_s1, res_data_s1, acc_s1;
   logic [2:0] alu_sel_s1;
   logic       cmd_ready_s3, res_valid_s3, res_zero_s3, res_carry_s3;
   logic [7:0] alu_a_s3, alu_b_s3, alu_out_s3, res_data_s3, acc_s3;
   logic [2:0] alu_sel_s3;

   logic       cmd_ready_m, res_valid_m, res_zero_m, res_carry_m;
   logic [7:0] alu_a_m, alu_b_m, res_data_m, acc_m;
   logic [2:0] alu_sel_m;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [7:0]  acc_ref [2];

   always #5 clk = ~clk;

   // Behavioural alu; opcode 111 returns a packed nibble mix
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] s);
      case (s)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return a ^ b;
         3'b101:  return ~a;
         3'b110:  return ~(a & b);
         default: return {a[3:0], b[3:0]};
      endcase
   endfunction

   assign alu_out_s1 = alu_model(alu_a_s1, alu_b_s1, alu_sel_s1);
   assign alu_out_s3 = alu_model(alu_a_s3, alu_b_s3, alu_sel_s3);

   assign cmd_ready_m = sel ? cmd_ready_s3 : cmd_ready_s1;
   assign res_valid_m = sel ? res_valid_s3 : res_valid_s1;
   assign res_zero_m  = sel ? res_zero_s3  : res_zero_s1;
   assign res_carry_m = sel ? res_carry_s3 : res_carry_s1;
   assign res_data_m  = sel ? res_data_s3  : res_data_s1;
   assign acc_m       = sel ? acc_s3       : acc_s1;
   assign alu_a_m     = sel ? alu_a_s3     : alu_a_s1;
   assign alu_b_m     = sel ? alu_b_s3     : alu_b_s1;
   assign alu_sel_m   = sel ? alu_sel_s3   : alu_sel_s1;

   alu_issue_ctrl #(.WIDTH(8), .SETTLE(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_s1),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a_s1), .alu_b(alu_b_s1), .alu_sel(alu_sel_s1), .alu_out(alu_out_s1),
      .res_valid(res_valid_s1), .res_ready(res_ready & ~sel),
      .res_data(res_data_s1), .res_zero(res_zero_s1), .res_carry(res_carry_s1),
      .acc(acc_s1)
   );

   alu_issue_ctrl #(.WIDTH(8), .SETTLE(3)) dut_s3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_s3),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a_s3), .alu_b(alu_b_s3), .alu_sel(alu_sel_s3), .alu_out(alu_out_s3),
      .res_valid(res_valid_s3), .res_ready(res_ready & sel),
      .res_data(res_data_s3), .res_zero(res_zero_s3), .res_carry(res_carry_s3),
      .acc(acc_s3)
   );

   // Single comparison point: counts and reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, settle, capture, optional backpressure, handshake
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input int hold);
      int         s   = sel ? 3 : 1;
      int         idx = sel ? 1 : 0;
      int         ai, bi, r;
      logic       c;
      logic [7:0] ae;
      int         waitc = 0;

      while (!cmd_ready_m && waitc < 20) begin
         step;
         waitc++;
      end
      check("cmd_ready_wait", cmd_ready_m, 1);

      ae = ua ? acc_ref[idx] : a;
      ai = ae;
      bi = b;
      c  = 1'b0;
      case (op)
         3'd0: begin r = (ai + bi) % 256; c = (ai + bi) > 255; end
         3'd1: begin r = (ai - bi + 256) % 256; c = ai < bi; end
         3'd2: r = ai & bi;
         3'd3: r = ai | bi;
         3'd4: r = ai ^ bi;
         3'd5: r = 255 - ai;
         3'd6: r = 255 - (ai & bi);
         default: r = (ai % 16) * 16 + (bi % 16);
      endcase

      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_use_acc = ua;
      step;
      cmd_valid   = 1'b0;
      cmd_op      = 3'($urandom);
      cmd_a       = 8'($urandom);
      cmd_b       = 8'($urandom);
      cmd_use_acc = 1'($urandom);

      check("busy_ready", cmd_ready_m, 0);
      check("alu_a", alu_a_m, ae);
      check("alu_b", alu_b_m, b);
      check("alu_sel", alu_sel_m, op);

      for (int i = 1; i < s; i++) begin
         step;
         check("early_valid", res_valid_m, 0);
      end
      step;
      check("res_valid", res_valid_m, 1);
      check("res_data", res_data_m, r);
      check("res_zero", res_zero_m, (r == 0));
      check("res_carry", res_carry_m, c);
      check("acc", acc_m, r);

      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_a     = 8'($urandom);
         step;
         check("bp_valid", res_valid_m, 1);
         check("bp_data", res_data_m, r);
         check("bp_flags", {res_zero_m, res_carry_m}, {(r == 0), c});
         check("bp_ready", cmd_ready_m, 0);
      end
      cmd_valid = 1'b0;

      acc_ref[idx] = 8'(r);
      res_ready = 1'b1;
      step;
      res_ready = 1'b0;
      check("post_valid", res_valid_m, 0);
      check("post_ready", cmd_ready_m, 1);
   endtask

   task automatic random_cmds(input int n);
      for (int k = 0; k < n; k++)
         issue(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      sel         = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = 3'b011;
      cmd_a       = 8'h5A;
      cmd_b       = 8'hA5;
      cmd_use_acc = 1'b0;
      res_ready   = 1'b0;
      acc_ref[0]  = '0;
      acc_ref[1]  = '0;

      // Reset with a command pending
      repeat (3) step;
      check("rst_ready", cmd_ready_m, 1);
      check("rst_valid", res_valid_m, 0);
      rst_n = 1'b1;
      check("rel_ready", cmd_ready_m, 1);
      check("rel_valid", res_valid_m, 0);
      check("rel_acc", acc_m, 0);
      check("rel_alu", {alu_sel_m, alu_a_m, alu_b_m}, 0);
      check("rel_s3", {cmd_ready_s3, res_valid_s3, acc_s3, alu_sel_s3}, {1'b1, 1'b0, 8'h00, 3'b000});
      cmd_valid = 1'b0;
      step;
      check("no_accept", cmd_ready_m, 1);

      // SETTLE=1 directed
      issue(3'b000, 8'h05, 8'h03, 1'b0, 0);
      issue(3'b010, 8'hFF, 8'h0C, 1'b1, 5);
      issue(3'b000, 8'hF0, 8'h20, 1'b0, 0);
      issue(3'b001, 8'h03, 8'h05, 1'b0, 1);
      issue(3'b001, 8'h05, 8'h05, 1'b0, 0);
      issue(3'b010, 8'hFF, 8'h0F, 1'b0, 0);
      issue(3'b111, 8'h3C, 8'hC7, 1'b0, 0);
      issue(3'b000, 8'hFF, 8'h01, 1'b0, 0);
      random_cmds(25);

      // SETTLE=3 directed and random
      sel = 1'b1;
      step;
      issue(3'b101, 8'h05, 8'h00, 1'b0, 0);
      random_cmds(15);

      // Abort mid-EXEC with an asynchronous reset
      cmd_valid = 1'b1;
      cmd_op    = 3'b101;
      cmd_a     = 8'h33;
      cmd_use_acc = 1'b0;
      step;
      cmd_valid = 1'b0;
      step;
      rst_n = 1'b0;
      #1;
      check("abort_valid", res_valid_m, 0);
      check("abort_acc", acc_m, 0);
      check("abort_ready", cmd_ready_m, 1);
      check("abort_sel", alu_sel_m, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         check("abort_hold", res_valid_m, 0);
      end
      rst_n = 1'b1;
      acc_ref[0] = '0;
      acc_ref[1] = '0;
      check("abort_rel_ready", cmd_ready_m, 1);
      issue(3'b000, 8'hEE, 8'h07, 1'b1, 0);

      sel = 1'b0;
      step;
      issue(3'b011, 8'hEE, 8'h10, 1'b1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue and capture stage for the 8-bit combinational alu.
- Accepts operation commands over a valid/ready handshake and registers the operands and opcode.
- Drives the alu's a, b and sel inputs, waits a programmable settle time, then captures the alu result.
- Captures the result into an accumulator with zero/carry flags and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 8: datapath width; must equal the alu width.
- SETTLE, 1: cycles the alu inputs are held before capture. Legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command.
- cmd_op, input, 3: alu opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 nand, 111 alu default).
- cmd_a, input, WIDTH: operand A.
- cmd_b, input, WIDTH: operand B.
- cmd_use_acc, input, 1: 1 = use the accumulator as operand A instead of cmd_a.
- alu_a, output, WIDTH: to alu a.
- alu_b, output, WIDTH: to alu b.
- alu_sel, output, 3: to alu sel.
- alu_out, input, WIDTH: from alu out.
- res_valid, output, 1: result present.
- res_ready, input, 1: downstream accepts the result.
- res_data, output, WIDTH: captured result.
- res_zero, output, 1: res_data == 0.
- res_carry, output, 1: add carry-out / sub borrow; 0 for all other ops.
- acc, output, WIDTH: accumulator (last captured result).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; settle counter = 0.
  - a_reg = b_reg = op_reg = 0, so alu_a = alu_b = 0 and alu_sel = 000.
  - res_data = 0, res_zero = 0, res_carry = 0, acc = 0, res_valid = 0.
- cmd_ready = (state == IDLE), combinational from state, so it reads 1 during and after reset.
- alu_a, alu_b and alu_sel are driven directly from the registers. They are stable throughout EXEC and RESP and hold their last values in IDLE.
- States:
  - IDLE: on cmd_valid && cmd_ready:
    - a_reg = cmd_use_acc ? acc : cmd_a
    - b_reg = cmd_b
    - op_reg = cmd_op
    - counter = SETTLE-1
    - go to EXEC
    - cmd_valid while not in IDLE is ignored; the command is not consumed.
  - EXEC: if counter != 0, decrement. If counter == 0, on this edge:
    - res_data = alu_out
    - acc = alu_out
    - res_zero = (alu_out == 0)
    - res_carry: op 000 → bit WIDTH of the (WIDTH+1)-bit sum a_reg + b_reg; op 001 → (a_reg < b_reg) unsigned; otherwise 0
    - go to RESP
  - RESP: res_valid = 1. On res_ready, go to IDLE and clear res_valid.
    - res_data, flags and acc stay stable while res_valid && !res_ready.
- Latency: accept at edge N → res_valid registered high after edge N+SETTLE.
- Throughput: one command per SETTLE+2 cycles when res_ready is held high. There is no overlap; the next accept occurs at edge N+SETTLE+2.
- Flags are computed locally from a_reg/b_reg, never from alu_out width overflow. The alu provides only WIDTH bits.
- Accumulator wraps modulo 2^WIDTH; there is no saturation.
- Opcode 111 is passed through unchanged; whatever the alu returns is captured, with carry = 0.
- Reset asserted mid-EXEC or mid-RESP: operation aborted, no res_valid pulse, acc cleared. After release, first cycle is IDLE with cmd_ready = 1.
- cmd_valid && cmd_ready on the same edge that reset releases: command not accepted.

Test Plan:
- Reset: hold rst_n low 3 cycles, drive cmd_valid = 1 → after release: cmd_ready = 1, res_valid = 0, acc = 0, alu_sel = 000, alu_a = alu_b = 0; no command taken before the first post-release edge.
- ADD, SETTLE = 1: cmd a = 0x05, b = 0x03, op = 000 → alu_a = 05, alu_b = 03, alu_sel = 000 one cycle after accept; res_valid next edge with res_data = 0x08, zero = 0, carry = 0, acc = 0x08; cmd_ready returns 1 one cycle after res_ready handshake.
- Flags:
  - ADD 0xF0 + 0x20 → res_data 0x10, carry 1.
  - SUB 0x03 - 0x05 → res_data 0xFE, carry 1.
  - SUB 0x05 - 0x05 → res_data 0x00, zero 1, carry 0.
  - AND 0xFF, 0x0F → 0x0F, carry 0.
- Accumulator chain plus backpressure: acc = 0x08, cmd_use_acc = 1, op = 010, b = 0x0C, cmd_a = 0xFF → alu_a = 0x08, res_data = 0x08. Hold res_ready = 0 for 5 cycles with cmd_valid = 1 → res_valid, res_data and flags stable, cmd_ready = 0, no second accept.
- SETTLE = 3, op = 101, a = 0x05 → res_valid exactly 3 edges after accept, res_data = 0xFA. Repeat and pull rst_n low during EXEC → no res_valid, acc = 0, state IDLE.
